// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM states,
// the default HALT opcode and the width of one queued fetch entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Instruction word width returned by the instruction memory.
  localparam int INSTR_W = 16;

  // Opcode field instr[15:11] that marks HALT unless overridden.
  localparam logic [4:0] HALT_OP_DEF = 5'b00000;

  // One queue entry carries {pc, instr}.
  function automatic int entry_width(input int addr_w);
    return INSTR_W + addr_w;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch block, the instruction memory and decode.
// The fetch block is the master of both the memory port and the
// instruction stream towards decode.
interface fetch_if #(
  parameter int ADDR_WIDTH = 16
) ();

  // Instruction memory port (single-cycle, combinational read data).
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_en;
  logic                  mem_wr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  // Instruction stream to decode (valid/ready).
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_pc2;

  modport master (
    output mem_addr, mem_en, mem_wr, mem_wdata,
    input  mem_rdata,
    output out_valid, out_instr, out_pc, out_pc2,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_en, mem_wr, mem_wdata,
    output mem_rdata,
    input  out_valid, out_instr, out_pc, out_pc2,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// flush empties the queue and overrides any push or pop in the same cycle.
// The caller never pushes into a full queue.
module fetch_queue #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [ENTRY_W-1:0]            data,
  output logic [$clog2(DEPTH):0]        count,
  output logic [ENTRY_W-1:0]            head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] store_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               pop_ok;
  logic               push_ok;

  assign pop_ok  = pop  && (count_q != '0) && !flush;
  assign push_ok = push && !flush;

  // Entry storage: written on push, no reset needed (gated by count).
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store_q[wr_ptr_q] <= data;
    end
  end

  // Pointer and occupancy bookkeeping; flush returns to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign count = count_q;
  assign head  = store_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the single-cycle
// instruction memory, queues returned instructions and hands them to
// decode over valid/ready. Redirect flushes and restarts fetching;
// a fetched HALT stops further fetches once it has been queued.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2,
  parameter logic [4:0]            HALT_OP    = HALT_OP_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_if.master               bus,
  output logic                  halted
);

  localparam int ENTRY_W = entry_width(ADDR_WIDTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  fetch;
  logic                  pop;
  logic                  head_vld;
  logic [CNT_W-1:0]      count;
  logic [ENTRY_W-1:0]    head;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [INSTR_W-1:0]    head_instr;

  // Next sequential fetch address; wraps naturally at 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] pc_plus2(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(2);
  endfunction

  // Instruction addresses are halfword aligned.
  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
    return {pc[ADDR_WIDTH-1:1], 1'b0};
  endfunction

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[15:11] == HALT_OP;
  endfunction

  // Fetch uses the occupancy before this cycle's pop, so out_ready never
  // reaches mem_en combinationally.
  assign fetch    = (state_q == ST_RUN) && (count < CNT_W'(DEPTH)) && !redirect_valid;
  assign head_vld = (count != '0);
  assign pop      = head_vld && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect wins over every other event.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN:    if (fetch && is_halt(bus.mem_rdata)) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // PC: reload on redirect, advance by one halfword per accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= align_pc(RESET_PC);
    end else if (redirect_valid) begin
      pc_q <= align_pc(redirect_pc);
    end else if (fetch) begin
      pc_q <= pc_plus2(pc_q);
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .data  ({pc_q, bus.mem_rdata}),
    .count (count),
    .head  (head)
  );

  assign head_pc    = head[ENTRY_W-1:INSTR_W];
  assign head_instr = head[INSTR_W-1:0];

  // Memory port: read-only, address is the live PC.
  assign bus.mem_addr  = pc_q;
  assign bus.mem_en    = fetch;
  assign bus.mem_wr    = 1'b0;
  assign bus.mem_wdata = '0;

  // Decode side: head fields read as zero while the queue is empty.
  assign bus.out_valid = head_vld;
  assign bus.out_instr = head_vld ? head_instr : '0;
  assign bus.out_pc    = head_vld ? head_pc : '0;
  assign bus.out_pc2   = head_vld ? pc_plus2(head_pc) : '0;

  assign halted = (state_q == ST_HALTED) && !head_vld;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized programs with
// random decode backpressure, checked against a program-order model.
module tb_fetch_ctrl;

  localparam logic [4:0] HALT_OP = 5'b00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        halted;

  logic        start_w = 1'b0;
  logic        redirect_valid_w = 1'b0;
  logic [15:0] redirect_pc_w = '0;
  logic        ready_w = 1'b0;
  logic        halted_w;

  logic [15:0] imem [0:32767];

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_pc[$];
  logic [15:0] exp_in[$];

  always #5 clk = ~clk;

  fetch_if #(.ADDR_WIDTH(16)) bif ();
  fetch_if #(.ADDR_WIDTH(16)) bif_w ();

  assign bif.mem_rdata   = imem[bif.mem_addr[15:1]];
  assign bif.out_ready   = out_ready;
  assign bif_w.mem_rdata = imem[bif_w.mem_addr[15:1]];
  assign bif_w.out_ready = ready_w;

  fetch_ctrl #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000),
    .DEPTH      (2),
    .HALT_OP    (HALT_OP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bif),
    .halted         (halted)
  );

  fetch_ctrl #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'hFFFE),
    .DEPTH      (4),
    .HALT_OP    (HALT_OP)
  ) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_w),
    .redirect_valid (redirect_valid_w),
    .redirect_pc    (redirect_pc_w),
    .bus            (bif_w),
    .halted         (halted_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    ready_w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic redirect_to(input logic [15:0] rpc);
    redirect_pc = rpc;
    redirect_valid = 1'b1;
    #1;
    chk("redir_no_fetch", 32'(bif.mem_en), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    #1;
    chk("redir_valid_low", 32'(bif.out_valid), 32'd0);
    chk("redir_halted_low", 32'(halted), 32'd0);
    chk("redir_fetch", 32'(bif.mem_en), 32'd1);
    chk("redir_addr", 32'(bif.mem_addr), 32'({rpc[15:1], 1'b0}));
  endtask

  // Reference: program order from spc up to and including the first HALT.
  task automatic build_model(input logic [15:0] spc);
    logic [15:0] pc;
    logic [15:0] w;
    exp_pc.delete();
    exp_in.delete();
    pc = spc;
    for (int k = 0; k < 64; k++) begin
      w = imem[pc[15:1]];
      exp_pc.push_back(pc);
      exp_in.push_back(w);
      if (w[15:11] == HALT_OP) break;
      pc = pc + 16'd2;
    end
  endtask

  // Runs the main DUT until halted; checks fetch addresses, delivered
  // stream and halted latency against the model. pre_fetched counts
  // fetches already observed by the caller.
  task automatic run_stream(input logic [15:0] spc, input bit rnd, input int pre_fetched);
    logic [15:0] fa[$];
    logic [15:0] gp[$];
    logic [15:0] gi[$];
    logic [15:0] g2[$];
    int hp = -1;
    int cyc = 0;
    bit done = 1'b0;
    build_model(spc);
    while (!done && cyc < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (halted) begin
        chk("halt_latency", 32'(cyc - hp), 32'd1);
        done = 1'b1;
      end else begin
        if (bif.mem_en) fa.push_back(bif.mem_addr);
        if (bif.out_valid && out_ready) begin
          gp.push_back(bif.out_pc);
          gi.push_back(bif.out_instr);
          g2.push_back(bif.out_pc2);
          if (bif.out_instr[15:11] == HALT_OP) hp = cyc;
        end
      end
      step();
      cyc++;
    end
    if (!done) chk("halt_timeout", 32'd0, 32'd1);
    chk("n_fetch", 32'(fa.size() + pre_fetched), 32'(exp_pc.size()));
    for (int k = 0; k < fa.size() && k + pre_fetched < exp_pc.size(); k++)
      chk("fetch_addr", 32'(fa[k]), 32'(exp_pc[k + pre_fetched]));
    chk("n_pop", 32'(gp.size()), 32'(exp_pc.size()));
    for (int k = 0; k < gp.size() && k < exp_pc.size(); k++) begin
      chk("pop_pc", 32'(gp[k]), 32'(exp_pc[k]));
      chk("pop_instr", 32'(gi[k]), 32'(exp_in[k]));
      chk("pop_pc2", 32'(g2[k]), 32'(exp_pc[k] + 16'd2));
    end
  endtask

  initial begin
    logic [15:0] base;
    logic [15:0] ha[$];
    logic [15:0] wp[$];
    logic [15:0] w2[$];
    logic [15:0] wi[$];
    int nfe;
    int len;

    for (int k = 0; k < 32768; k++) imem[k] = 16'hFFFF;
    imem[0] = 16'h1234;
    imem[1] = 16'h2345;
    imem[2] = 16'h3456;
    imem[3] = 16'h0000;
    imem[16'h7FFF] = 16'hABCD;

    // Reset state
    do_reset();
    #1;
    chk("rst_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_mem_en", 32'(bif.mem_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instr", 32'(bif.out_instr), 32'd0);
    chk("rst_pc", 32'(bif.out_pc), 32'd0);
    chk("rst_pc2", 32'(bif.out_pc2), 32'd0);
    chk("rst_addr", 32'(bif.mem_addr), 32'd0);
    chk("rst_wr", 32'({bif.mem_wr, bif.mem_wdata}), 32'd0);
    chk("rst_addr_w", 32'(bif_w.mem_addr), 32'hFFFE);
    repeat (2) begin
      @(negedge clk);
      chk("idle_no_fetch", 32'(bif.mem_en), 32'd0);
      step();
    end

    // Basic stream
    pulse_start();
    run_stream(16'h0000, 1'b0, 0);

    // Redirect out of HALTED
    imem[8]  = 16'h1111;
    imem[9]  = 16'h2222;
    imem[10] = 16'h0005;
    chk("halted_before_redir", 32'(halted), 32'd1);
    redirect_to(16'h0010);
    run_stream(16'h0010, 1'b0, 0);

    // Backpressure
    do_reset();
    pulse_start();
    out_ready = 1'b0;
    nfe = 0;
    ha.delete();
    repeat (5) begin
      @(negedge clk);
      if (bif.mem_en) begin
        nfe++;
        ha.push_back(bif.mem_addr);
      end
      step();
    end
    chk("bp_n_fetch", 32'(nfe), 32'd2);
    if (ha.size() == 2) begin
      chk("bp_addr0", 32'(ha[0]), 32'h0000);
      chk("bp_addr1", 32'(ha[1]), 32'h0002);
    end
    chk("bp_valid", 32'(bif.out_valid), 32'd1);
    chk("bp_instr", 32'(bif.out_instr), 32'h1234);
    chk("bp_pc", 32'(bif.out_pc), 32'h0000);
    chk("bp_pc2", 32'(bif.out_pc2), 32'h0002);
    run_stream(16'h0000, 1'b0, 2);

    // Redirect mid-stream with a full queue
    imem[16'h20] = 16'hA001;
    imem[16'h21] = 16'hB002;
    imem[16'h22] = 16'h0800;
    imem[16'h23] = 16'h07FF;
    do_reset();
    pulse_start();
    out_ready = 1'b0;
    repeat (3) step();
    chk("full_valid", 32'(bif.out_valid), 32'd1);
    out_ready = 1'b1;
    redirect_to(16'h0041);
    run_stream(16'h0040, 1'b0, 0);

    // Randomized programs entered by redirect from HALTED
    for (int it = 0; it < 6; it++) begin
      base = 16'($urandom_range(32'h100, 32'h7000) & 32'hFFFE);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++)
        imem[base[15:1] + 15'(k)] = {5'($urandom_range(1, 31)), 11'($urandom)};
      imem[base[15:1] + 15'(len)] = {HALT_OP, 11'($urandom)};
      redirect_to(base | 16'($urandom_range(0, 1)));
      run_stream(base, 1'b1, 0);
    end

    // Address wrap on the DEPTH=4 instance
    ready_w = 1'b1;
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    for (int c = 0; c < 40 && !halted_w; c++) begin
      @(negedge clk);
      if (bif_w.out_valid) begin
        wp.push_back(bif_w.out_pc);
        w2.push_back(bif_w.out_pc2);
        wi.push_back(bif_w.out_instr);
      end
      step();
    end
    chk("wrap_halted", 32'(halted_w), 32'd1);
    chk("wrap_n_pop", 32'(wp.size()), 32'd5);
    if (wp.size() >= 2) begin
      chk("wrap_pc0", 32'(wp[0]), 32'hFFFE);
      chk("wrap_pc2_0", 32'(w2[0]), 32'h0000);
      chk("wrap_instr0", 32'(wi[0]), 32'hABCD);
      chk("wrap_pc1", 32'(wp[1]), 32'h0000);
      chk("wrap_pc2_1", 32'(w2[1]), 32'h0002);
      chk("wrap_instr1", 32'(wi[1]), 32'h1234);
    end

    // Asynchronous reset between clock edges
    do_reset();
    pulse_start();
    out_ready = 1'b1;
    repeat (3) step();
    chk("pre_arst_valid", 32'(bif.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bif.out_valid), 32'd0);
    chk("arst_mem_en", 32'(bif.mem_en), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_addr", 32'(bif.mem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_idle_fetch", 32'(bif.mem_en), 32'd0);
      chk("arst_idle_valid", 32'(bif.out_valid), 32'd0);
      step();
    end
    pulse_start();
    run_stream(16'h0000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Initiator side of the single-cycle instruction memory interface.
- Owns the PC and drives byte addresses, read enable and write-low into the instruction memory.
- Captures each combinationally returned 16-bit instruction into a small queue, and hands instructions to decode over a valid/ready handshake.
- Handles redirect from execute and stops fetching after a HALT instruction.

Parameters:
- ADDR_WIDTH, 16: memory byte-address width. The PC is ADDR_WIDTH bits and bit 0 is always 0.
- RESET_PC, 16'h0000: PC value loaded at reset.
- DEPTH, 2: instruction queue entries. Must be 2 or 4.
- HALT_OP, 5'b00000: opcode in instr[15:11] that marks HALT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
- redirect_valid  in  1  flush the queue and refetch from redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch address; bit 0 ignored (forced 0).
- mem_addr  out  ADDR_WIDTH  byte address to memory (equals pc).
- mem_en  out  1  memory enable; 1 only on cycles a fetch is accepted.
- mem_wr  out  1  constant 0.
- mem_wdata  out  16  constant 0.
- mem_rdata  in  16  combinational read data; valid in the same cycle as mem_en.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  16  head instruction.
- out_pc  out  ADDR_WIDTH  head instruction address.
- out_pc2  out  ADDR_WIDTH  out_pc+2, modulo 2^ADDR_WIDTH.
- halted  out  1  HALT has been dequeued and no fetch is pending.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, queue empty.
  - Outputs: out_valid=0, mem_en=0, halted=0, out_instr/out_pc/out_pc2=0.
- States: IDLE, RUN, HALTED.
  - IDLE -> RUN on start.
  - RUN -> HALTED on the fetch cycle whose mem_rdata[15:11]==HALT_OP.
  - Any state -> RUN on redirect_valid (IDLE included).
  - HALTED stays until redirect_valid or reset; start is ignored outside IDLE.
- Fetch condition: mem_en = (state==RUN) & (count<DEPTH) & ~redirect_valid. Count is the value before this cycle's pop, so there is no combinational path from out_ready to mem_en.
- On a fetch cycle:
  - push {pc, mem_rdata} at the tail.
  - pc <= pc+2, wrapping from 2^ADDR_WIDTH-2 to 0.
  - Zero extra latency: the instruction appears at the head (out_valid=1) the cycle after mem_en if the queue was empty.
- Pop: out_valid & out_ready. Push and pop in the same cycle are allowed; count stays unchanged.
- Steady state: with out_ready held 1, one instruction per cycle after a 1-cycle startup bubble.
- Redirect has priority over everything in the same cycle:
  - queue cleared (count=0), so pending pushes and pops are discarded.
  - pc <= {redirect_pc[ADDR_WIDTH-1:1],1'b0}, state <= RUN, halted <= 0.
  - No fetch that cycle; out_valid=0 the next cycle; first refetch issues the next cycle.
- Halt:
  - The HALT instruction itself is queued and delivered normally.
  - No fetches occur after it.
  - halted=1 from the cycle after HALT is popped, while state==HALTED and the queue is empty.
- Backpressure: out_ready=0 with a full queue holds the head stable (instr, pc, pc2 unchanged) and holds pc.
- Memory contract: never read and write concurrently (mem_wr is always 0); mem_addr stable while mem_en=1.

Decomposition:
- Shared package fetch_pkg:
  - state encoding constants for IDLE/RUN/HALTED.
  - HALT_OP default.
  - queue entry width constant (16+ADDR_WIDTH).
- One sub-module: fetch_queue, a synchronous FIFO of DEPTH entries.
  - ports: push, pop, flush, data, count, head.
  - flush dominates push and pop.
- fetch_ctrl holds pc, the state machine and the memory drive.

Test Plan:
- Basic stream: memory at 0..6 = 1234,2345,3456,0000; reset, start, out_ready=1 -> out_instr sequence 1234/2345/3456/0000 with out_pc 0,2,4,6; no mem_en after addr 6; halted=1 one cycle after 0000 popped.
- Backpressure: out_ready=0 for 5 cycles after start -> exactly DEPTH mem_en pulses (addr 0,2), head stays 1234/pc 0; release -> order preserved, no duplicate or drop.
- Redirect mid-stream: redirect_valid with redirect_pc=16'h0041 while queue full -> next cycle out_valid=0, then mem_addr=0x0040, and the first delivered out_pc=0x0040.
- Redirect out of HALTED: after halted=1, redirect_pc=0x0010 -> halted drops, fetch resumes at 0x0010.
- Wrap: RESET_PC=16'hFFFE, start -> out_pc FFFE then 0000, with out_pc2 0000 then 0002.
- Async reset mid-run: rst_n low between clock edges -> out_valid, mem_en, halted are 0 immediately; pc=RESET_PC; IDLE until start.
